alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//  Age-ordered reservation station for ALU ops, directly downstream of instr_decode.
//  Captures decoded ops (stationRequest with RSstation==2'b00) and their operand values or ROB tags.
//  Snoops the CDB to wake up busy operands, and issues the oldest ready entry to the ALU.
//  Drives ALUFull back to decode as the freeze source for ALU-class instructions.
// PARAMETERS
//  WIDTH    31  MSB index of data/operand buses (32-bit)
//  ROB      2   MSB index of ROB tag (8 entries)
//  A_WIDTH  3   MSB index of ALUControl (4-bit)
//  ENTRIES  4   station depth; power of two, >=2
// PORTS
//  clk              in   1        clock; all state updates on posedge
//  globalResetN     in   1        synchronous, active-low reset
//  flush            in   1        pipeline flush (ROB controlFlow[0] & validCommit); clears station
//  stationRequest   in   1        decode requests a station entry
//  RSstation        in   2        target station; only 2'b00 is accepted here
//  ALUControl       in   A_WIDTH+1  ALU op code
//  operand1/2       in   WIDTH+1  source values (operand2 = immExt when useImm)
//  busy1/busy2      in   1        source still pending in ROB
//  rob1/rob2        in   ROB+1    ROB tag producing each pending source
//  useImm           in   1        operand2 is an immediate; forces op2 ready
//  robInstr         in   ROB+1    ROB entry of this instruction (result tag)
//  cdbValid         in   1        CDB broadcast valid
//  cdbROB           in   ROB+1    CDB producer tag
//  cdbResult        in   WIDTH+1  CDB value
//  aluReady         in   1        ALU accepts an issue this cycle
//  ALUFull          out  1        count==ENTRIES (combinational from count)
//  issueValid       out  1        a ready entry is presented
//  issueOp1/issueOp2 out WIDTH+1  operands of issued entry
//  issueALUControl  out  A_WIDTH+1  op code of issued entry
//  issueROB         out  ROB+1    destination ROB tag of issued entry
//  count            out  $clog2(ENTRIES)+1  valid entries
// BEHAVIOUR
//  - Storage: compacting queue; slot 0 = oldest. Per slot: valid, aluC, v1, v2, rdy1, rdy2, tag1, tag2, robDst.
//  - Alloc: stationRequest & RSstation==2'b00 & !ALUFull writes slot[count] at posedge.
//    rdy1 = !busy1; rdy2 = !busy2 | useImm. An accepted request is written exactly once.
//    Decode never presents the same instruction on two cycles with stationRequest high.
//  - Wakeup: for every valid slot with !rdyN & cdbValid & tagN==cdbROB: vN<=cdbResult, rdyN<=1 (both sources independently).
//  - Same-cycle wakeup: the incoming alloc also compares against the CDB.
//    A match captures cdbResult instead of operandN; ready next cycle.
//  - Issue select (comb): lowest-index slot with valid&rdy1&rdy2.
//    issueValid=1 and issue* outputs from that slot; else issueValid=0, issue* = 0.
//  - Issue handshake: issueValid & aluReady removes the slot at posedge.
//    Higher slots shift down one position, preserving age order.
//  - Min latency: alloc at edge N with ready sources -> issueValid in cycle N+1.
//    Source woken by CDB in cycle N -> issueable in cycle N+1.
//  - Simultaneous issue+alloc: count unchanged; new entry lands at slot count-1 after compaction.
//  - Full + issue same cycle: ALUFull still 1 that cycle (no bypass); alloc is refused.
//  - Empty: issueValid=0; count never underflows.
//  - Priority: !globalResetN > flush > {issue, alloc, wakeup}.
//  - Reset/flush: all valid=0, count=0, all state cleared.
//    issueValid=0, issue*=0, ALUFull=0 in the following cycle. Any in-cycle alloc/issue is discarded.
//  - ALUControl 4'b1111 (decode bubble) is never allocated: decode holds stationRequest=0 for bubbles.
// CONFIGURATION
//  RS_PERF_EN defined: adds output stallCycles[15:0].
//    Increments each cycle with stationRequest & RSstation==2'b00 & ALUFull.
//    Saturates at 16'hFFFF; cleared by reset only, not by flush.
//  RS_PERF_EN undefined: port and counter absent; no other behaviour change.
// TESTING
//  1. Reset low 2 cycles, then alloc op1=5 op2=7 both ready, tag 3 -> next cycle issueValid=1, issueOp1=5, issueOp2=7, issueROB=3.
//  2. Alloc busy1=1 rob1=2; after one idle cycle CDB cdbROB=2 cdbResult=32'hAA -> next cycle issueOp1=32'hAA, issueValid=1.
//  3. Alloc busy1=1 rob1=6 while cdbValid, cdbROB=6, cdbResult=9 in the same cycle -> entry ready next cycle with issueOp1=9.
//  4. aluReady=0, fill 4 ready entries tags 0..3 -> ALUFull=1, 5th request refused.
//     Then aluReady=1 -> issue order tags 0,1,2,3, count decrements each cycle.
//  5. Slot0 not ready, slot1 ready, aluReady=1 -> slot1 issues first; slot0 stays in slot0, count 2->1.
//  6. 3 valid entries, flush asserted with simultaneous alloc -> count=0, issueValid=0 next cycle, alloc discarded.

Source files
------------

// File: rtl/alu_reservation_station.sv
// Age-ordered ALU reservation station with CDB wakeup and oldest-ready issue.
// Optional RS_PERF_EN adds a saturating stallCycles counter output.
module alu_reservation_station #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int A_WIDTH = 3,
    parameter int ENTRIES = 4
) (
    input  logic                        clk,
    input  logic                        globalResetN,
    input  logic                        flush,
    input  logic                        stationRequest,
    input  logic [1:0]                  RSstation,
    input  logic [A_WIDTH:0]            ALUControl,
    input  logic [WIDTH:0]              operand1,
    input  logic [WIDTH:0]              operand2,
    input  logic                        busy1,
    input  logic                        busy2,
    input  logic [ROB:0]                rob1,
    input  logic [ROB:0]                rob2,
    input  logic                        useImm,
    input  logic [ROB:0]                robInstr,
    input  logic                        cdbValid,
    input  logic [ROB:0]                cdbROB,
    input  logic [WIDTH:0]              cdbResult,
    input  logic                        aluReady,
    output logic                        ALUFull,
    output logic                        issueValid,
    output logic [WIDTH:0]              issueOp1,
    output logic [WIDTH:0]              issueOp2,
    output logic [A_WIDTH:0]            issueALUControl,
    output logic [ROB:0]                issueROB,
`ifdef RS_PERF_EN
    output logic [15:0]                 stallCycles,
`endif
    output logic [$clog2(ENTRIES):0]    count
);

    localparam int IW = $clog2(ENTRIES);
    localparam int CW = IW + 1;

    logic             r_valid  [ENTRIES];
    logic [A_WIDTH:0] r_aluC   [ENTRIES];
    logic [WIDTH:0]   r_v1     [ENTRIES];
    logic [WIDTH:0]   r_v2     [ENTRIES];
    logic             r_rdy1   [ENTRIES];
    logic             r_rdy2   [ENTRIES];
    logic [ROB:0]     r_tag1   [ENTRIES];
    logic [ROB:0]     r_tag2   [ENTRIES];
    logic [ROB:0]     r_robDst [ENTRIES];
    logic [CW-1:0]    r_count;

    // Post-wakeup view; the extra top slot is an empty filler for compaction.
    logic             w_wk_valid  [ENTRIES+1];
    logic [A_WIDTH:0] w_wk_aluC   [ENTRIES+1];
    logic [WIDTH:0]   w_wk_v1     [ENTRIES+1];
    logic [WIDTH:0]   w_wk_v2     [ENTRIES+1];
    logic             w_wk_rdy1   [ENTRIES+1];
    logic             w_wk_rdy2   [ENTRIES+1];
    logic [ROB:0]     w_wk_tag1   [ENTRIES+1];
    logic [ROB:0]     w_wk_tag2   [ENTRIES+1];
    logic [ROB:0]     w_wk_robDst [ENTRIES+1];

    logic             w_n_valid  [ENTRIES];
    logic [A_WIDTH:0] w_n_aluC   [ENTRIES];
    logic [WIDTH:0]   w_n_v1     [ENTRIES];
    logic [WIDTH:0]   w_n_v2     [ENTRIES];
    logic             w_n_rdy1   [ENTRIES];
    logic             w_n_rdy2   [ENTRIES];
    logic [ROB:0]     w_n_tag1   [ENTRIES];
    logic [ROB:0]     w_n_tag2   [ENTRIES];
    logic [ROB:0]     w_n_robDst [ENTRIES];
    logic [CW-1:0]    w_n_count;

    logic             w_full;
    logic             w_alloc;
    logic             w_issue;
    logic             w_found;
    logic [IW-1:0]    w_sel;
    logic [CW-1:0]    w_allocIdx;
    logic             w_match1;
    logic             w_pend2;
    logic             w_match2;

    assign w_full  = (r_count == CW'(ENTRIES));
    assign w_alloc = stationRequest && (RSstation == 2'b00) && !w_full;
    assign w_issue = w_found && aluReady;

    assign ALUFull = w_full;
    assign count   = r_count;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i]) begin
                w_found = 1'b1;
                w_sel   = IW'(i);
            end
        end
    end

    always_comb begin
        issueValid      = w_found;
        issueOp1        = '0;
        issueOp2        = '0;
        issueALUControl = '0;
        issueROB        = '0;
        if (w_found) begin
            issueOp1        = r_v1[w_sel];
            issueOp2        = r_v2[w_sel];
            issueALUControl = r_aluC[w_sel];
            issueROB        = r_robDst[w_sel];
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_wk_valid[i]  = r_valid[i];
            w_wk_aluC[i]   = r_aluC[i];
            w_wk_v1[i]     = r_v1[i];
            w_wk_v2[i]     = r_v2[i];
            w_wk_rdy1[i]   = r_rdy1[i];
            w_wk_rdy2[i]   = r_rdy2[i];
            w_wk_tag1[i]   = r_tag1[i];
            w_wk_tag2[i]   = r_tag2[i];
            w_wk_robDst[i] = r_robDst[i];
            if (r_valid[i] && !r_rdy1[i] && cdbValid
                && r_tag1[i] == cdbROB) begin
                w_wk_v1[i]   = cdbResult;
                w_wk_rdy1[i] = 1'b1;
            end
            if (r_valid[i] && !r_rdy2[i] && cdbValid
                && r_tag2[i] == cdbROB) begin
                w_wk_v2[i]   = cdbResult;
                w_wk_rdy2[i] = 1'b1;
            end
        end
        w_wk_valid[ENTRIES]  = 1'b0;
        w_wk_aluC[ENTRIES]   = '0;
        w_wk_v1[ENTRIES]     = '0;
        w_wk_v2[ENTRIES]     = '0;
        w_wk_rdy1[ENTRIES]   = 1'b0;
        w_wk_rdy2[ENTRIES]   = 1'b0;
        w_wk_tag1[ENTRIES]   = '0;
        w_wk_tag2[ENTRIES]   = '0;
        w_wk_robDst[ENTRIES] = '0;
    end

    // Incoming op also snoops the CDB so a same-cycle broadcast is not lost.
    assign w_match1 = busy1 && cdbValid && (rob1 == cdbROB);
    assign w_pend2  = busy2 && !useImm;
    assign w_match2 = w_pend2 && cdbValid && (rob2 == cdbROB);

    assign w_allocIdx = r_count - CW'(w_issue);
    assign w_n_count  = r_count + CW'(w_alloc) - CW'(w_issue);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_issue && IW'(i) >= w_sel) begin
                w_n_valid[i]  = w_wk_valid[i+1];
                w_n_aluC[i]   = w_wk_aluC[i+1];
                w_n_v1[i]     = w_wk_v1[i+1];
                w_n_v2[i]     = w_wk_v2[i+1];
                w_n_rdy1[i]   = w_wk_rdy1[i+1];
                w_n_rdy2[i]   = w_wk_rdy2[i+1];
                w_n_tag1[i]   = w_wk_tag1[i+1];
                w_n_tag2[i]   = w_wk_tag2[i+1];
                w_n_robDst[i] = w_wk_robDst[i+1];
            end else begin
                w_n_valid[i]  = w_wk_valid[i];
                w_n_aluC[i]   = w_wk_aluC[i];
                w_n_v1[i]     = w_wk_v1[i];
                w_n_v2[i]     = w_wk_v2[i];
                w_n_rdy1[i]   = w_wk_rdy1[i];
                w_n_rdy2[i]   = w_wk_rdy2[i];
                w_n_tag1[i]   = w_wk_tag1[i];
                w_n_tag2[i]   = w_wk_tag2[i];
                w_n_robDst[i] = w_wk_robDst[i];
            end
            if (w_alloc && CW'(i) == w_allocIdx) begin
                w_n_valid[i]  = 1'b1;
                w_n_aluC[i]   = ALUControl;
                w_n_v1[i]     = w_match1 ? cdbResult : operand1;
                w_n_v2[i]     = w_match2 ? cdbResult : operand2;
                w_n_rdy1[i]   = !busy1 || w_match1;
                w_n_rdy2[i]   = !w_pend2 || w_match2;
                w_n_tag1[i]   = rob1;
                w_n_tag2[i]   = rob2;
                w_n_robDst[i] = robInstr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!globalResetN || flush) begin
            r_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_aluC[i]   <= '0;
                r_v1[i]     <= '0;
                r_v2[i]     <= '0;
                r_rdy1[i]   <= 1'b0;
                r_rdy2[i]   <= 1'b0;
                r_tag1[i]   <= '0;
                r_tag2[i]   <= '0;
                r_robDst[i] <= '0;
            end
        end else begin
            r_count <= w_n_count;
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= w_n_valid[i];
                r_aluC[i]   <= w_n_aluC[i];
                r_v1[i]     <= w_n_v1[i];
                r_v2[i]     <= w_n_v2[i];
                r_rdy1[i]   <= w_n_rdy1[i];
                r_rdy2[i]   <= w_n_rdy2[i];
                r_tag1[i]   <= w_n_tag1[i];
                r_tag2[i]   <= w_n_tag2[i];
                r_robDst[i] <= w_n_robDst[i];
            end
        end
    end

`ifdef RS_PERF_EN
    logic [15:0] r_stall;

    // Flush does not clear this; it measures decode back-pressure over the run.
    always_ff @(posedge clk) begin
        if (!globalResetN) begin
            r_stall <= '0;
        end else if (stationRequest && RSstation == 2'b00 && w_full
                     && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stallCycles = r_stall;
`endif

endmodule
